fetch_align_queue: RTL and testbench
====================================

FETCH_ALIGN_QUEUE -- requirements
Module: fetch_align_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 64, bit width of one instruction entry.
REQ-002 Parameter FETCH_WIDTH, default 4, number of write lanes per fetch packet.
REQ-003 Parameter ISSUE_WIDTH, default 2, number of read lanes.
REQ-004 Parameter DEPTH, default 16, number of entries; SHALL be a power of two and >= FETCH_WIDTH+ISSUE_WIDTH.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, reset; it is synchronous and active-low.
REQ-007 Port flush_i, input, 1, discard all queued entries.
REQ-008 Port write_valid_i, input, 1, producer offers a fetch packet.
REQ-009 Port write_ready_o, output, 1, queue can accept a full packet this cycle.
REQ-010 Port write_mask_i, input, FETCH_WIDTH, per-lane valid bits; any pattern, including non-contiguous.
REQ-011 Port write_data_i, input, FETCH_WIDTH*DATA_WIDTH, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Port read_valid_o, output, ISSUE_WIDTH, bit k set when entry head+k is present.
REQ-013 Port read_data_o, output, ISSUE_WIDTH*DATA_WIDTH, entry head+k on lane k.
REQ-014 Port read_ready_i, input, 1, consumer not stalled; pops permitted.
REQ-015 Port read_num_i, input, $clog2(ISSUE_WIDTH+1), number of entries consumed this cycle.
REQ-016 Port count_o, output, $clog2(DEPTH+1), current occupancy.

Function
REQ-017 Storage: circular buffer of DEPTH entries, head and tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus occupancy counter.
REQ-018 write_ready_o SHALL be 1 iff count <= DEPTH-FETCH_WIDTH, from registered count only (no dependence on same-cycle pop).
REQ-019 Push occurs iff write_valid_i & write_ready_o & ~flush_i; write_valid_i while write_ready_o=0 is ignored with no state change.
REQ-020 On push, mask-set lanes are compacted and appended at tail in ascending lane order; push count = popcount(write_mask_i); tail advances by push count.
REQ-021 Mask all-zero push accepted, no state change.
REQ-022 read_valid_o thermometer: bit k = (count > k); lanes with bit clear drive read_data_o zero.
REQ-023 read_data_o combinational from storage at head; an entry written in cycle N is visible in cycle N+1 (one-cycle write-to-read latency).
REQ-024 Pop amount = read_ready_i ? min(read_num_i, count) : 0; read_num_i above count saturates, never underflows; forced 0 while flush_i.
REQ-025 Simultaneous push and pop: count_next = count - pop + push; no overflow possible by REQ-018.
REQ-026 flush_i takes priority over push and pop: next cycle head=tail=0, count=0.
REQ-027 count_o equals registered count; read_valid_o and write_ready_o derive from it.

Reset
REQ-028 rst_n low at a rising clk edge: head=0, tail=0, count=0; takes priority over flush_i, push and pop.
REQ-029 During and after reset: read_valid_o=0, read_data_o=0, count_o=0, write_ready_o=1.
REQ-030 Storage array not reset; content unreachable until rewritten.

Verification (FETCH_WIDTH=4, ISSUE_WIDTH=2, DEPTH=16, DATA_WIDTH=64)
REQ-031 Reset; push mask 4'b1010, lanes A0..A3 -> next cycle count_o=2, read_valid_o=2'b11, lane0=A1, lane1=A3.
REQ-032 Four full pushes, no pops -> count_o=16, write_ready_o=0 from count 13; further write_valid_i ignored, count stays 16.
REQ-033 count=12, push 4 lanes and pop read_num_i=2 same cycle -> count_o=14, write_ready_o=0, order preserved.
REQ-034 Drive head to 14, push 4 lanes B0..B3 -> entries in slots 14,15,0,1; pops return B0,B1 then B2,B3.
REQ-035 count=1, read_ready_i=1, read_num_i=2 -> pop 1, count_o=0, read_valid_o=2'b00; read_ready_i=0 with read_num_i=2 -> no pop.
REQ-036 count=9, flush_i=1 with simultaneous valid push and pop -> next cycle count_o=0, read_valid_o=0, write_ready_o=1; rst_n low same cycle gives identical result.

Source files
------------

// File: rtl/fetch_align_queue_if.sv
// fetch_align_queue_if: fetch-packet write side and issue read side of the align queue
interface fetch_align_queue_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int FETCH_WIDTH = 4,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 16
);
    logic                               flush_i;
    logic                               write_valid_i;
    logic                               write_ready_o;
    logic [FETCH_WIDTH-1:0]             write_mask_i;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0]  write_data_i;
    logic [ISSUE_WIDTH-1:0]             read_valid_o;
    logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  read_data_o;
    logic                               read_ready_i;
    logic [$clog2(ISSUE_WIDTH+1)-1:0]   read_num_i;
    logic [$clog2(DEPTH+1)-1:0]         count_o;

    modport master (
        output flush_i, write_valid_i, write_mask_i, write_data_i, read_ready_i, read_num_i,
        input  write_ready_o, read_valid_o, read_data_o, count_o
    );
    modport slave (
        input  flush_i, write_valid_i, write_mask_i, write_data_i, read_ready_i, read_num_i,
        output write_ready_o, read_valid_o, read_data_o, count_o
    );
endinterface

// File: rtl/fetch_align_queue.sv
// fetch_align_queue: circular buffer compacting masked fetch lanes, popping up to ISSUE_WIDTH per cycle
module fetch_align_queue #(
    parameter int DATA_WIDTH  = 64,
    parameter int FETCH_WIDTH = 4,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_align_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count, cnt, rn, pop_n;
    logic [PW-1:0]         off [FETCH_WIDTH];
    logic                  wr_ok, push;

    assign wr_ok           = count <= CW'(DEPTH - FETCH_WIDTH);
    assign push            = q.write_valid_i & wr_ok & ~q.flush_i;
    assign q.write_ready_o = wr_ok;
    assign q.count_o       = count;
    assign rn              = CW'(q.read_num_i);
    assign pop_n           = (q.read_ready_i & ~q.flush_i) ? (rn < count ? rn : count) : '0;

    // each set lane lands at tail plus the number of set lanes below it
    always_comb begin
        cnt = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            off[k] = PW'(cnt);
            cnt    = cnt + CW'(q.write_mask_i[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || q.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_n);
            tail  <= tail + (push ? PW'(cnt) : '0);
            count <= count - pop_n + (push ? cnt : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            for (int k = 0; k < FETCH_WIDTH; k++)
                if (q.write_mask_i[k])
                    mem[tail + off[k]] <= q.write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_rd
        assign q.read_valid_o[i] = count > CW'(i);
        assign q.read_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
            q.read_valid_o[i] ? mem[head + PW'(i)] : '0;
    end
endmodule

// File: tb/tb_fetch_align_queue.sv
// tb_fetch_align_queue: directed and random stimulus against a queue-based reference model
module tb_fetch_align_queue;
    logic clk = 0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [63:0] mq[$];
    logic [63:0] a [4];
    logic [63:0] b [4];

    always #5 clk = ~clk;

    fetch_align_queue_if bus ();
    fetch_align_queue dut (.clk(clk), .rst_n(rst_n), .q(bus.slave));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic compare_all();
        int sz = mq.size();
        logic [1:0] rv;
        rv[0] = sz > 0;
        rv[1] = sz > 1;
        check("count", 128'(bus.count_o), 128'(sz));
        check("wready", 128'(bus.write_ready_o), 128'(sz <= 12));
        check("rvalid", 128'(bus.read_valid_o), 128'(rv));
        check("rdata0", 128'(bus.read_data_o[63:0]), 128'(sz > 0 ? mq[0] : 64'h0));
        check("rdata1", 128'(bus.read_data_o[127:64]), 128'(sz > 1 ? mq[1] : 64'h0));
    endtask

    // inputs applied after a falling edge, state observed at the next falling edge
    task automatic drive(input logic r, input logic f, input logic wv, input logic [3:0] m,
                         input logic [255:0] d, input logic rr, input logic [1:0] rn);
        int sz = mq.size();
        int p;
        rst_n = r;
        bus.flush_i = f;
        bus.write_valid_i = wv;
        bus.write_mask_i = m;
        bus.write_data_i = d;
        bus.read_ready_i = rr;
        bus.read_num_i = rn;
        if (!r || f) mq.delete();
        else begin
            p = rr ? (int'(rn) < sz ? int'(rn) : sz) : 0;
            repeat (p) void'(mq.pop_front());
            if (wv && sz <= 12)
                for (int k = 0; k < 4; k++)
                    if (m[k]) mq.push_back(d[k*64 +: 64]);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [255:0] rnd_pkt();
        return {rnd64(), rnd64(), rnd64(), rnd64()};
    endfunction

    initial begin
        logic [255:0] d;
        rst_n = 0;
        bus.flush_i = 0;
        bus.write_valid_i = 0;
        bus.write_mask_i = 0;
        bus.write_data_i = 0;
        bus.read_ready_i = 0;
        bus.read_num_i = 0;
        @(negedge clk);
        drive(0, 0, 1, 4'hf, rnd_pkt(), 1, 2);
        check("reset_wready", 128'(bus.write_ready_o), 128'(1));

        for (int k = 0; k < 4; k++) a[k] = rnd64();
        drive(1, 0, 1, 4'b1010, {a[3], a[2], a[1], a[0]}, 0, 0);
        check("mask1010_lane0", 128'(bus.read_data_o[63:0]), 128'(a[1]));
        check("mask1010_lane1", 128'(bus.read_data_o[127:64]), 128'(a[3]));
        check("mask1010_count", 128'(bus.count_o), 128'(2));

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 1, 4'hf, rnd_pkt(), 0, 0);
        check("full_count", 128'(bus.count_o), 128'(16));
        drive(1, 0, 1, 4'hf, rnd_pkt(), 0, 0);
        check("full_ignored", 128'(bus.count_o), 128'(16));
        drive(1, 0, 1, 4'h0, rnd_pkt(), 1, 2);
        drive(1, 0, 1, 4'h0, rnd_pkt(), 1, 2);
        drive(1, 0, 1, 4'hf, rnd_pkt(), 1, 2);
        check("push_pop_count", 128'(bus.count_o), 128'(14));
        check("push_pop_wready", 128'(bus.write_ready_o), 128'(0));

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (7) drive(1, 0, 1, 4'b0011, rnd_pkt(), 1, 2);
        drive(1, 0, 0, 0, 0, 1, 2);
        for (int k = 0; k < 4; k++) b[k] = rnd64();
        drive(1, 0, 1, 4'hf, {b[3], b[2], b[1], b[0]}, 0, 0);
        check("wrap_b0", 128'(bus.read_data_o[63:0]), 128'(b[0]));
        check("wrap_b1", 128'(bus.read_data_o[127:64]), 128'(b[1]));
        drive(1, 0, 0, 0, 0, 1, 2);
        check("wrap_b2", 128'(bus.read_data_o[63:0]), 128'(b[2]));
        check("wrap_b3", 128'(bus.read_data_o[127:64]), 128'(b[3]));
        drive(1, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1, 2);
        check("sat_count", 128'(bus.count_o), 128'(0));
        check("sat_rvalid", 128'(bus.read_valid_o), 128'(0));

        drive(1, 0, 1, 4'hf, rnd_pkt(), 0, 0);
        drive(1, 0, 1, 4'hf, rnd_pkt(), 0, 2);
        drive(1, 0, 1, 4'h1, rnd_pkt(), 0, 2);
        check("stall_count", 128'(bus.count_o), 128'(9));
        drive(1, 1, 1, 4'hf, rnd_pkt(), 1, 2);
        check("flush_count", 128'(bus.count_o), 128'(0));
        check("flush_wready", 128'(bus.write_ready_o), 128'(1));
        drive(1, 0, 1, 4'hf, rnd_pkt(), 0, 0);
        drive(1, 0, 1, 4'hf, rnd_pkt(), 0, 0);
        drive(1, 0, 1, 4'h1, rnd_pkt(), 0, 0);
        drive(0, 1, 1, 4'hf, rnd_pkt(), 1, 2);
        check("rst_flush_count", 128'(bus.count_o), 128'(0));

        for (int i = 0; i < 3000; i++) begin
            d = rnd_pkt();
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, 4'($urandom), d,
                  $urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
